// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the shared RAM and the arbiter.
// Request/response: a requester raises mX_valid with addr/wdata/wstrb; the arbiter
// samples it only while idle and answers with a single-cycle mX_ready pulse.
// mX_rdata is meaningful while mX_ready is high. There is no back-pressure.
interface mem_arbiter_if #(parameter int ADDR_W = 14);
    logic              m0_valid;
    logic [31:0]       m0_addr;
    logic [31:0]       m0_wdata;
    logic [3:0]        m0_wstrb;
    logic              m0_ready;
    logic [31:0]       m0_rdata;

    logic              m1_valid;
    logic [31:0]       m1_addr;
    logic [31:0]       m1_wdata;
    logic [3:0]        m1_wstrb;
    logic              m1_ready;
    logic [31:0]       m1_rdata;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [1:0]        grant;
    logic              err;

    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  ram_rdata,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output grant, err
    );

    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output ram_rdata,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  grant, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM (IDLE -> ACCESS -> RESP).
// Define MEM_ARBITER_FIXED_PRIO_EN for fixed priority to requester 0; default is round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 14
) (
    input  logic           clk,
    input  logic           resetn,
    mem_arbiter_if.slave   bus,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              win_q, win_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              oor_q, oor_d;
    logic [31:0]       m0_rdata_q, m0_rdata_d;
    logic [31:0]       m1_rdata_q, m1_rdata_d;

    logic              pick;
    logic [31:0]       sel_addr;
    logic [31:0]       resp_rdata;
    logic              is_read;
    logic              in_access;
    logic              in_resp;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{bus.m0_addr[1:0], bus.m1_addr[1:0]};

    always_comb begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        pick = !bus.m0_valid;
`else
        // On a tie the requester not served last wins.
        pick = (bus.m0_valid && bus.m1_valid) ? !last_q : bus.m1_valid;
`endif
        sel_addr = pick ? bus.m1_addr : bus.m0_addr;
    end

    assign is_read    = (wstrb_q == 4'b0000);
    assign resp_rdata = oor_q ? 32'h0 : bus.ram_rdata;
    assign in_access  = (state_q == ACCESS);
    assign in_resp    = (state_q == RESP);

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        oor_d      = oor_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.m0_valid || bus.m1_valid) begin
                    win_d   = pick;
                    last_d  = pick;
                    addr_d  = sel_addr[ADDR_W+1:2];
                    wdata_d = pick ? bus.m1_wdata : bus.m0_wdata;
                    wstrb_d = pick ? bus.m1_wstrb : bus.m0_wstrb;
                    oor_d   = |sel_addr[31:ADDR_W+2];
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                // Writes leave the requester's last read data untouched.
                if (is_read && !win_q) m0_rdata_d = resp_rdata;
                if (is_read && win_q)  m1_rdata_d = resp_rdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            win_q      <= 1'b0;
            last_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'b0000;
            oor_q      <= 1'b0;
            m0_rdata_q <= 32'h0;
            m1_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            oor_q      <= oor_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Outputs decode from the state register so asynchronous reset clears them at once.
    assign bus.ram_en    = in_access && !oor_q;
    assign bus.ram_we    = (in_access && !oor_q) ? wstrb_q : 4'b0000;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;

    assign bus.m0_ready  = in_resp && !win_q;
    assign bus.m1_ready  = in_resp && win_q;
    assign bus.m0_rdata  = (in_resp && !win_q && is_read) ? resp_rdata : m0_rdata_q;
    assign bus.m1_rdata  = (in_resp && win_q && is_read) ? resp_rdata : m1_rdata_q;

    assign bus.grant     = (state_q == IDLE) ? 2'b00 : (win_q ? 2'b10 : 2'b01);
    assign bus.err       = in_resp && oor_q;

    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM model, timing checks in the driver and a
// scoreboard monitor comparing every ready pulse against a queue of expected responses.
module tb_mem_arbiter;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  dbg_state;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rd [2];

    // {port, err, rdata}
    logic [33:0] exp_q[$];

    logic [31:0] mem [0:16383];
    logic        mem_init = 1'b0;

    mem_arbiter_if #(.ADDR_W(14)) bus ();

    mem_arbiter #(.ADDR_W(14)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic apply_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
    endtask

    // ---------------- RAM model ----------------
    always @(posedge clk) begin
        if (!mem_init) begin
            mem[4]   <= 32'hDEAD_BEEF;
            mem[8]   <= 32'hAAAA_BBBB;
            mem[12]  <= 32'h5555_0000;
            mem_init <= 1'b1;
        end else if (bus.ram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [33:0] e;
        if (bus.m0_ready || bus.m1_ready) begin
            check("single_ready", {31'h0, bus.m0_ready && bus.m1_ready}, 32'h0);
            if (exp_q.size() == 0) begin
                check("unexpected_ready", {30'h0, bus.m1_ready, bus.m0_ready}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("ready_port", {31'h0, bus.m1_ready}, {31'h0, e[33]});
                check("rdata", e[33] ? bus.m1_rdata : bus.m0_rdata, e[31:0]);
                check("err_with_ready", {31'h0, bus.err}, {31'h0, e[32]});
            end
        end else if (bus.err) begin
            check("err_without_ready", {31'h0, bus.err}, 32'h0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit port, input logic v, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        if (port) begin
            bus.m1_valid = v; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_wstrb = wstrb;
        end else begin
            bus.m0_valid = v; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_wstrb = wstrb;
        end
    endtask

    // One-cycle valid pulse; inputs are scrambled after the sampling edge.
    task automatic single(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rdata, input logic exp_err);
        exp_q.push_back({port, exp_err, exp_rdata});
        drive(port, 1'b1, addr, wdata, wstrb);
        @(posedge clk);
        #1 drive(port, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_0BAD, 4'b1111);
        @(negedge clk);
        check("access_state", {30'h0, dbg_state}, {30'h0, S_ACCESS});
        check("access_grant", {30'h0, bus.grant}, port ? 32'd2 : 32'd1);
        check("ram_en", {31'h0, bus.ram_en}, {31'h0, !exp_err});
        check("ram_we", {28'h0, bus.ram_we}, exp_err ? 32'h0 : {28'h0, wstrb});
        if (!exp_err) check("ram_addr", {18'h0, bus.ram_addr}, {18'h0, addr[15:2]});
        if (!exp_err) check("ram_wdata", bus.ram_wdata, wdata);
        @(negedge clk);
        check("resp_ready", {30'h0, bus.m1_ready, bus.m0_ready}, port ? 32'd2 : 32'd1);
        @(negedge clk);
        check("back_idle", {30'h0, dbg_state, bus.grant}, {28'h0, S_IDLE, 2'b00});
        if (wstrb == 4'b0000) last_rd[port] = exp_rdata;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] exp_grant;
        int         wait_cnt;
        resetn = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'b0);
        repeat (3) @(negedge clk);
        check("rst_state", {30'h0, dbg_state}, {30'h0, S_IDLE});
        check("rst_outputs", {22'h0, bus.grant, bus.ram_en, bus.ram_we, bus.err, bus.m0_ready, bus.m1_ready},
              32'h0);
        check("rst_ram_addr", {18'h0, bus.ram_addr}, 32'h0);
        check("rst_m0_rdata", bus.m0_rdata, 32'h0);
        check("rst_m1_rdata", bus.m1_rdata, 32'h0);
        resetn = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(negedge clk);

        // Basic read, partial write with rdata hold, readback, full write, out-of-range.
        single(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0);
        single(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, last_rd[1], 1'b0);
        single(1'b1, 32'h0000_0023, 32'h0, 4'b0000, 32'hAAAA_5678, 1'b0);
        single(1'b0, 32'h0000_0014, 32'hCAFE_F00D, 4'b1111, last_rd[0], 1'b0);
        single(1'b0, 32'h0000_0014, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0);
        single(1'b0, 32'h0001_0000, 32'h0, 4'b0000, 32'h0, 1'b1);
        single(1'b1, 32'h0000_FFFC, 32'h0, 4'b0000, 32'hxxxx_xxxx, 1'b0);

        // Both requesters held valid straight after reset.
        apply_reset();
        drive(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'b0000);
        drive(1'b1, 1'b1, 32'h0000_0020, 32'h0, 4'b0000);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
            exp_grant = 2'b01;
`else
            exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            exp_q.push_back(exp_grant[1] ? {2'b10, 32'hAAAA_5678} : {2'b00, 32'hDEAD_BEEF});
            @(posedge clk);
            if (k == 3) begin
                #1;
                drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0);
                drive(1'b1, 1'b0, 32'h0, 32'h0, 4'b0);
            end
            @(negedge clk);
            check("rr_grant", {30'h0, bus.grant}, {30'h0, exp_grant});
            @(negedge clk);
            @(negedge clk);
        end
        check("rr_done_idle", {30'h0, dbg_state}, {30'h0, S_IDLE});

        // Reset while an m1 write is on the RAM port.
        drive(1'b1, 1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b1111);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 32'h0, 32'h0, 4'b0);
        @(negedge clk);
        check("pre_rst_we", {28'h0, bus.ram_we}, 32'hF);
        #2 resetn = 1'b0;
        #1;
        check("rst_cut_we", {28'h0, bus.ram_we}, 32'h0);
        check("rst_cut_misc", {27'h0, bus.ram_en, bus.grant, bus.m1_ready, bus.m0_ready}, 32'h0);
        check("rst_cut_state", {30'h0, dbg_state}, {30'h0, S_IDLE});
        @(negedge clk);
        check("rst_no_ready", {30'h0, bus.m1_ready, bus.m0_ready}, 32'h0);
        resetn = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(negedge clk);
        check("post_rst_idle", {30'h0, dbg_state}, {30'h0, S_IDLE});
        single(1'b1, 32'h0000_0030, 32'h0, 4'b0000, 32'h5555_0000, 1'b0);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("queue_drained", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word-address width of the shared RAM (16384 x 32-bit words).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports m0_valid/m1_valid  input  1  requester 0 (CPU) / requester 1 (cache/DMA) request.
REQ-005 SHALL have ports m0_addr/m1_addr  input  32  byte address; bits [1:0] ignored.
REQ-006 SHALL have ports m0_wdata/m1_wdata  input  32  write data.
REQ-007 SHALL have ports m0_wstrb/m1_wstrb  input  4  byte strobes; 4'b0000 = read.
REQ-008 SHALL have ports m0_ready/m1_ready  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports m0_rdata/m1_rdata  output  32  read data, valid when matching ready is high.
REQ-010 SHALL have port ram_en  output  1  RAM access enable.
REQ-011 SHALL have port ram_we  output  4  RAM byte write enables.
REQ-012 SHALL have port ram_addr  output  ADDR_W  RAM word address.
REQ-013 SHALL have port ram_wdata  output  32  RAM write data.
REQ-014 SHALL have port ram_rdata  input  32  RAM read data, valid one cycle after ram_en.
REQ-015 SHALL have port grant  output  2  one-hot current owner, 2'b00 when idle.
REQ-016 SHALL have port err  output  1  one-cycle pulse on out-of-range access.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; no other transitions except reset.
REQ-018 In IDLE with any valid high, SHALL latch winner's addr/wdata/wstrb, set grant, go to ACCESS next cycle; with none, stay IDLE.
REQ-019 Arbitration SHALL be round-robin: single requester wins; on simultaneous valid, the requester not served last wins.
REQ-020 In ACCESS, SHALL drive ram_en=1, ram_addr=addr[ADDR_W+1:2], ram_we=latched wstrb, ram_wdata=latched wdata for exactly one cycle.
REQ-021 In RESP, SHALL pulse winner's ready for one cycle; for reads its rdata=ram_rdata, for writes rdata holds its previous value.
REQ-022 Latency SHALL be: valid sampled in IDLE at cycle N -> ram_en at N+1 -> ready at N+2; next arbitration at N+3.
REQ-023 Loser's ready SHALL stay 0; loser's request SHALL be served in the next IDLE if still valid.
REQ-024 Out of range (addr[31:2] >= 2**ADDR_W) SHALL keep ram_en=0 and ram_we=0 in ACCESS, return rdata=32'h0 with ready in RESP, and pulse err with ready.
REQ-025 Valid dropped after grant SHALL NOT abort; access completes and ready still pulses.
REQ-026 Inputs SHALL be sampled only in IDLE; changes during ACCESS/RESP are ignored.
REQ-027 grant SHALL be one-hot from ACCESS through RESP, 2'b00 in IDLE.

Reset
REQ-028 resetn low SHALL immediately force: state IDLE, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, grant=0, err=0, last-served=requester 1.
REQ-029 Reset mid-ACCESS/RESP SHALL discard the transaction with no ready pulse; a write in ACCESS is cut off with the clock-edge-independent ram_we=0.
REQ-030 After resetn release, the first simultaneous request SHALL be granted to requester 0.

Configuration
REQ-031 Macro MEM_ARBITER_FIXED_PRIO_EN defined: requester 0 SHALL always win simultaneous requests (requester 1 may starve).
REQ-032 Macro MEM_ARBITER_FIXED_PRIO_EN undefined: round-robin per REQ-019.

Verification
REQ-033 m0 read addr 32'h0000_0010, RAM word 4 = 32'hDEAD_BEEF -> ram_en/ram_addr=4 at N+1, m0_ready with m0_rdata=32'hDEAD_BEEF at N+2.
REQ-034 m1 write addr 32'h0000_0020, wdata 32'h1234_5678, wstrb 4'b0011 -> ram_we=4'b0011, ram_addr=8 at N+1, m1_ready at N+2; readback gives 32'hxxxx_5678 low half.
REQ-035 m0 and m1 valid continuously after reset -> grants alternate 01,10,01,10 (round-robin); with MEM_ARBITER_FIXED_PRIO_EN, always 01.
REQ-036 m0 read addr 32'h0001_0000 (word 16384) -> ram_en stays 0, m0_ready with m0_rdata=0 and err pulse at N+2.
REQ-037 resetn low during ACCESS of an m1 write -> ram_we=0 immediately, no m1_ready, grant=0, state IDLE after release.
REQ-038 m0 valid for one cycle only then dropped -> access completes, m0_ready pulses at N+2, FSM returns to IDLE.
